// File: rtl/shot_controller.sv
// Cue aiming and shot launch: rotates the cue angle, charges power while the
// shoot key is held, and on release fires a one-cycle pulse with a launch velocity.
module shot_controller #(
  parameter int unsigned ROTATE_DIV = 2,
  parameter int unsigned CHARGE_DIV = 4,
  parameter int unsigned POWER_MAX  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic        drawLine,
  input  logic        gameFinished,
  input  logic        keyLeft,
  input  logic        keyRight,
  input  logic        keyShoot,
  output logic [5:0]  angle,
  output logic [3:0]  power,
  output logic        aimActive,
  output logic        charging,
  output logic        lineWriteEnable,
  output logic [11:0] velX,
  output logic [11:0] velY
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_AIM,
    S_CHARGE,
    S_CALC,
    S_FIRE
  } state_t;

  state_t             state_q, state_d;
  logic [5:0]         angle_q, angle_d;
  logic [3:0]         power_q, power_d;
  logic [3:0]         rot_cnt_q, rot_cnt_d;
  logic [3:0]         chg_cnt_q, chg_cnt_d;
  logic signed [11:0] vel_x_q, vel_x_d;
  logic signed [11:0] vel_y_q, vel_y_d;

  logic signed [11:0] pwr_s, sin_s, cos_s;

  // Quarter-wave table 127*sin(k*pi/32); quadrant folds the index and sign.
  function automatic logic signed [7:0] sin_lut(input logic [5:0] a);
    logic [4:0] idx;
    logic [6:0] mag;
    idx = a[4] ? (5'd16 - {1'b0, a[3:0]}) : {1'b0, a[3:0]};
    case (idx)
      5'd0:    mag = 7'd0;
      5'd1:    mag = 7'd12;
      5'd2:    mag = 7'd25;
      5'd3:    mag = 7'd37;
      5'd4:    mag = 7'd49;
      5'd5:    mag = 7'd60;
      5'd6:    mag = 7'd71;
      5'd7:    mag = 7'd81;
      5'd8:    mag = 7'd90;
      5'd9:    mag = 7'd98;
      5'd10:   mag = 7'd106;
      5'd11:   mag = 7'd112;
      5'd12:   mag = 7'd117;
      5'd13:   mag = 7'd122;
      5'd14:   mag = 7'd125;
      5'd15:   mag = 7'd126;
      5'd16:   mag = 7'd127;
      default: mag = 7'd0;
    endcase
    return a[5] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  endfunction

  always_comb begin
    pwr_s = $signed({8'b0, power_q});
    sin_s = 12'(sin_lut(angle_q));
    cos_s = 12'(sin_lut(angle_q + 6'd16));
  end

  always_comb begin
    state_d   = state_q;
    angle_d   = angle_q;
    power_d   = power_q;
    rot_cnt_d = rot_cnt_q;
    chg_cnt_d = chg_cnt_q;
    vel_x_d   = vel_x_q;
    vel_y_d   = vel_y_q;
    case (state_q)
      S_WAIT: begin
        power_d   = '0;
        rot_cnt_d = '0;
        chg_cnt_d = '0;
        // A shoot key still held from the previous shot must be released first.
        if (drawLine && !gameFinished && !keyShoot) state_d = S_AIM;
      end
      S_AIM: begin
        if (gameFinished || !drawLine) begin
          state_d = S_WAIT;
          power_d = '0;
        end else if (keyShoot) begin
          state_d   = S_CHARGE;
          power_d   = 4'd1;
          chg_cnt_d = '0;
        end else if (startOfFrame) begin
          if (keyLeft ^ keyRight) begin
            if (rot_cnt_q + 4'd1 == 4'(ROTATE_DIV)) begin
              rot_cnt_d = '0;
              angle_d   = keyRight ? angle_q + 6'd1 : angle_q - 6'd1;
            end else begin
              rot_cnt_d = rot_cnt_q + 4'd1;
            end
          end else begin
            rot_cnt_d = '0;
          end
        end
      end
      S_CHARGE: begin
        if (gameFinished || !drawLine) begin
          state_d = S_WAIT;
          power_d = '0;
        end else if (!keyShoot) begin
          state_d = S_CALC;
        end else if (startOfFrame) begin
          if (chg_cnt_q + 4'd1 == 4'(CHARGE_DIV)) begin
            chg_cnt_d = '0;
            if (power_q < 4'(POWER_MAX)) power_d = power_q + 4'd1;
          end else begin
            chg_cnt_d = chg_cnt_q + 4'd1;
          end
        end
      end
      S_CALC: begin
        vel_x_d = pwr_s * cos_s;
        vel_y_d = pwr_s * sin_s;
        state_d = S_FIRE;
      end
      S_FIRE: begin
        state_d = S_WAIT;
        power_d = '0;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_WAIT;
      angle_q   <= '0;
      power_q   <= '0;
      rot_cnt_q <= '0;
      chg_cnt_q <= '0;
      vel_x_q   <= '0;
      vel_y_q   <= '0;
    end else begin
      state_q   <= state_d;
      angle_q   <= angle_d;
      power_q   <= power_d;
      rot_cnt_q <= rot_cnt_d;
      chg_cnt_q <= chg_cnt_d;
      vel_x_q   <= vel_x_d;
      vel_y_q   <= vel_y_d;
    end
  end

  assign angle           = angle_q;
  assign power           = power_q;
  assign aimActive       = (state_q == S_AIM) || (state_q == S_CHARGE);
  assign charging        = (state_q == S_CHARGE);
  assign lineWriteEnable = (state_q == S_FIRE);
  assign velX            = vel_x_q;
  assign velY            = vel_y_q;

endmodule

// File: tb/tb_shot_controller.sv
// Directed bench for shot_controller; each release of the shoot key queues the
// expected shot, which is checked when the fire pulse appears.
module tb_shot_controller;

  logic        clk = 1'b0;
  logic        reset, startOfFrame, drawLine, gameFinished;
  logic        keyLeft, keyRight, keyShoot;
  logic [5:0]  angle;
  logic [3:0]  power;
  logic        aimActive, charging, lineWriteEnable;
  logic [11:0] velX, velY;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int cyc    = 0;

  typedef struct {
    int vx;
    int vy;
    int pw;
    int at_cyc;
  } shot_t;

  shot_t sb[$];

  shot_controller #(
    .ROTATE_DIV(2),
    .CHARGE_DIV(4),
    .POWER_MAX (15)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .startOfFrame   (startOfFrame),
    .drawLine       (drawLine),
    .gameFinished   (gameFinished),
    .keyLeft        (keyLeft),
    .keyRight       (keyRight),
    .keyShoot       (keyShoot),
    .angle          (angle),
    .power          (power),
    .aimActive      (aimActive),
    .charging       (charging),
    .lineWriteEnable(lineWriteEnable),
    .velX           (velX),
    .velY           (velY)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      startOfFrame = 1'b1;
      tick(1);
      startOfFrame = 1'b0;
      tick(3);
    end
  endtask

  task automatic release_shot(input int vx, input int vy, input int pw);
    shot_t s;
    s.vx = vx;
    s.vy = vy;
    s.pw = pw;
    s.at_cyc = cyc + 2;
    sb.push_back(s);
    keyShoot = 1'b0;
  endtask

  // Scoreboard side: every pulse must match a queued shot.
  always @(negedge clk) begin
    if (lineWriteEnable === 1'b1) begin
      pulses++;
      checks++;
      assert (sb.size() != 0)
      else begin
        errors++;
        $error("FAIL unexpected_pulse: observed pulse at cycle %0d expected none", cyc);
      end
      if (sb.size() != 0) begin
        shot_t s;
        s = sb.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(s.at_cyc));
        check("velX", 32'(signed'(velX)), 32'(s.vx));
        check("velY", 32'(signed'(velY)), 32'(s.vy));
        check("power_in_fire", 32'(power), 32'(s.pw));
      end
    end
  end

  initial begin
    reset = 1'b1; startOfFrame = 1'b0; drawLine = 1'b0; gameFinished = 1'b0;
    keyLeft = 1'b0; keyRight = 1'b0; keyShoot = 1'b0;
    tick(2);
    check("rst_angle", 32'(angle), 0);
    check("rst_power", 32'(power), 0);
    check("rst_aim", 32'(aimActive), 0);
    check("rst_charging", 32'(charging), 0);
    check("rst_lwe", 32'(lineWriteEnable), 0);
    check("rst_velX", 32'(signed'(velX)), 0);
    check("rst_velY", 32'(signed'(velY)), 0);

    reset = 1'b0; drawLine = 1'b1;
    tick(1);
    check("enter_aim", 32'(aimActive), 1);

    keyRight = 1'b1; frames(6); keyRight = 1'b0;
    check("rotate_right", 32'(angle), 3);
    keyLeft = 1'b1; frames(8); keyLeft = 1'b0;
    check("rotate_left_wrap", 32'(angle), 63);
    keyRight = 1'b1; frames(2); keyRight = 1'b0;
    check("wrap_to_zero", 32'(angle), 0);

    // Angle 0, charge for 9 frames -> power 3.
    keyShoot = 1'b1; tick(1);
    check("charge_start", 32'(charging), 1);
    check("charge_power1", 32'(power), 1);
    frames(9);
    check("charge_power3", 32'(power), 3);
    release_shot(381, 0, 3);
    tick(5);
    check("pulses_after_shot1", pulses, 1);
    check("power_cleared", 32'(power), 0);

    keyLeft = 1'b1; frames(48); keyLeft = 1'b0;
    check("angle_40", 32'(angle), 40);

    // Shoot pressed on the frame where a rotate step is due: no step.
    keyRight = 1'b1; frames(1);
    keyShoot = 1'b1; startOfFrame = 1'b1; tick(1); startOfFrame = 1'b0; tick(3);
    check("shoot_beats_rotate", 32'(angle), 40);
    check("charging_2", 32'(charging), 1);
    frames(80);
    check("angle_frozen", 32'(angle), 40);
    check("power_saturated", 32'(power), 15);
    keyRight = 1'b0;
    release_shot(-1350, -1350, 15);
    tick(5);
    check("pulses_after_shot2", pulses, 2);

    // Abort from CHARGE, then held shoot key keeps WAIT.
    keyShoot = 1'b1; tick(1);
    check("charging_3", 32'(charging), 1);
    frames(2);
    drawLine = 1'b0; tick(1);
    check("abort_aim", 32'(aimActive), 0);
    check("abort_power", 32'(power), 0);
    check("abort_angle_kept", 32'(angle), 40);
    drawLine = 1'b1; tick(5);
    check("held_shoot_blocks", 32'(aimActive), 0);
    keyShoot = 1'b0; tick(1);
    check("rearm_aim", 32'(aimActive), 1);
    check("no_pulse_abort", pulses, 2);

    keyLeft = 1'b1; keyRight = 1'b1; frames(10);
    keyLeft = 1'b0; keyRight = 1'b0;
    check("both_keys_hold", 32'(angle), 40);

    gameFinished = 1'b1; tick(1);
    check("gf_abort", 32'(aimActive), 0);
    for (int i = 0; i < 12; i++) begin
      keyShoot = i[0];
      keyRight = i[1];
      frames(1);
      check("gf_no_aim", 32'(aimActive), 0);
    end
    keyShoot = 1'b0; keyRight = 1'b0; tick(3);
    check("gf_no_pulse", pulses, 2);
    gameFinished = 1'b0;

    // Reset while in CALC drops the shot.
    tick(1);
    check("aim_again", 32'(aimActive), 1);
    keyShoot = 1'b1; tick(1);
    keyShoot = 1'b0; tick(1);
    reset = 1'b1; tick(1);
    check("calc_rst_angle", 32'(angle), 0);
    check("calc_rst_power", 32'(power), 0);
    check("calc_rst_aim", 32'(aimActive), 0);
    check("calc_rst_lwe", 32'(lineWriteEnable), 0);
    check("calc_rst_velX", 32'(signed'(velX)), 0);
    check("calc_rst_velY", 32'(signed'(velY)), 0);
    drawLine = 1'b0; tick(2);
    reset = 1'b0; tick(4);
    check("no_pulse_after_reset", pulses, 2);
    check("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shot_controller.md
Name: shot_controller

Overview:
- Cue-aiming and shot-launch stage that sits directly upstream of the game controller.
- Aiming is enabled while the game controller reports that the balls are stopped (drawLine). Keys rotate the cue angle; holding the shoot key charges power; releasing it fires.
- On fire, the block emits a one-cycle lineWriteEnable pulse, which the game controller uses to decrement attempts. In the same cycle it presents a signed launch velocity for the white ball, taken from a sine/cosine table.

Parameters:
- ROTATE_DIV, 2, number of startOfFrame ticks per angle step while a rotate key is held (legal 1..15).
- CHARGE_DIV, 4, number of startOfFrame ticks per power increment while charging (legal 1..15).
- POWER_MAX, 15, saturation value of power (legal 1..15).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse per video frame
- drawLine  in  1  high while the balls are stopped and aiming is allowed
- gameFinished  in  1  high once the game is over; blocks all shots
- keyLeft  in  1  level; rotate counter-clockwise (angle decrements)
- keyRight  in  1  level; rotate clockwise (angle increments)
- keyShoot  in  1  level; hold to charge, release to fire
- angle  out  6  cue direction, 0..63, in steps of 360/64 degrees; 0 = +X, 16 = +Y
- power  out  4  current charge, 0..POWER_MAX
- aimActive  out  1  high in the AIM or CHARGE state
- charging  out  1  high in the CHARGE state
- lineWriteEnable  out  1  one-cycle fire pulse
- velX  out  12  signed two's complement, power*cos(angle)
- velY  out  12  signed two's complement, power*sin(angle)

Behaviour:
- Key inputs are already synchronized and debounced upstream.
- Reset values: angle=0, power=0, aimActive=0, charging=0, lineWriteEnable=0, velX=0, velY=0, state=WAIT, frame counters=0.
- States: WAIT, AIM, CHARGE, CALC, FIRE.
- WAIT → AIM when drawLine=1, gameFinished=0 and keyShoot=0.
  - Requiring keyShoot released prevents a held key from re-firing.
  - power is cleared to 0 in WAIT.
- AIM:
  - Rotation is evaluated only on a startOfFrame cycle.
  - If exactly one rotate key is held, the rotate counter increments. When it reaches ROTATE_DIV, the counter clears and angle steps by ±1, wrapping modulo 64 (63+1→0, 0−1→63).
  - With both rotate keys or neither held, the counter clears and angle holds.
  - keyShoot=1 → CHARGE with power=1 and the charge counter cleared.
- CHARGE:
  - angle is frozen.
  - On each startOfFrame the charge counter increments. When it reaches CHARGE_DIV, the counter clears and power increments, saturating at POWER_MAX.
  - keyShoot=0 → CALC.
- CALC (1 cycle): velX and velY are registered from the current angle and power.
- FIRE (1 cycle): lineWriteEnable=1, then → WAIT.
  - velX/velY hold their value until the next CALC.
  - power holds in FIRE and clears on entry to WAIT.
- Latency: if keyShoot=0 is sampled in CHARGE at edge N, the state is CALC after edge N, velocity is valid after edge N+1, and lineWriteEnable is high for exactly the cycle following edge N+1.
- Abort:
  - In AIM or CHARGE, drawLine=0 or gameFinished=1 → WAIT with no pulse; power clears and angle is kept.
  - CALC and FIRE always complete.
  - gameFinished has priority over every key.
- Sine table T[0..16] = 0, 12, 25, 37, 49, 60, 71, 81, 90, 98, 106, 112, 117, 122, 125, 126, 127 (127·sin(k·π/32), rounded).
- Sine lookup: with q=a[5:4] and i=a[3:0], sin(a) is:
  - q=0: T[i]
  - q=1: T[16−i]
  - q=2: −T[i]
  - q=3: −T[16−i]
- cos(a) = sin((a+16) mod 64).
- Velocity arithmetic: the product is 4-bit unsigned power × 8-bit signed table value, sign-extended to 12 bits. The range is ±1905, so no overflow.
- Simultaneous keyShoot and a rotate key in AIM: the transition to CHARGE wins, and the angle does not step on that cycle.
- Synchronous reset asserted mid-operation returns all outputs to their reset values on the next edge. A FIRE pulse in progress is dropped.

Test Plan:
- Reset, then drawLine=1 and keyRight held for 6 frames (ROTATE_DIV=2) → angle=3; then keyLeft held for 8 frames → angle=63 (wraps through 0).
- angle=0, press keyShoot for 9 frames (CHARGE_DIV=4), then release → power=3; velX=+381, velY=0; lineWriteEnable high for exactly 1 cycle, 2 cycles after release.
- angle=40, charge held for 80 frames → power saturates at 15. After release, velX=15·cos(225°)=−1350 and velY=−1350, pulse once.
- Drop drawLine to 0 while in CHARGE → return to WAIT, no lineWriteEnable, power=0. Re-raise drawLine with keyShoot still held → stays in WAIT until keyShoot is released.
- gameFinished=1 with drawLine=1 and keys toggling → aimActive stays 0, no pulse ever.
- keyLeft and keyRight held together for 10 frames → angle unchanged. Assert reset during CALC → lineWriteEnable never fires, and all outputs return to 0.
